// File: rtl/bit_serializer.sv
// Word-to-bit serializer: one-entry input buffer feeding an LSB-first shift register with valid/ready on both sides.
// Optional macro BIT_SERIALIZER_EARLY_EXIT_EN ends a word once no set bits remain above the current bit.
module bit_serializer #(
    parameter int WIDTH = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_data,
    output logic             out_valid,
    input  logic             out_ready,
    output logic             out_bit,
    output logic             out_last,
    output logic             busy,
    output logic [7:0]       words_done
);

    localparam int CW = $clog2(WIDTH + 1);

    typedef enum logic {
        IDLE  = 1'b0,
        SHIFT = 1'b1
    } state_t;

    state_t           state_reg, state_next;
    logic [WIDTH-1:0] buf_data_reg, buf_data_next;
    logic             buf_full_reg, buf_full_next;
    logic [WIDTH-1:0] shreg_reg, shreg_next;
    logic [CW-1:0]    cnt_reg, cnt_next;
    logic [7:0]       words_done_reg, words_done_next;
    logic [WIDTH-1:0] shreg_shifted;
    logic             accept, consume, last_bit, shifting;

    // Zero-filled right shift of the shift register
    generate
        for (genvar gi = 0; gi < WIDTH; gi++) begin : g_shift
            if (gi == WIDTH - 1) begin : g_top
                assign shreg_shifted[gi] = 1'b0;
            end else begin : g_mid
                assign shreg_shifted[gi] = shreg_reg[gi+1];
            end
        end
    endgenerate

    assign shifting = (state_reg == SHIFT);
    assign accept   = in_valid && !buf_full_reg;
    assign consume  = shifting && out_ready;

`ifdef BIT_SERIALIZER_EARLY_EXIT_EN
    logic upper_zero;
    assign upper_zero = (shreg_shifted == '0);
    assign last_bit   = shifting && ((cnt_reg == CW'(1)) || upper_zero);
`else
    assign last_bit   = shifting && (cnt_reg == CW'(1));
`endif

    always_comb begin
        state_next      = state_reg;
        buf_data_next   = buf_data_reg;
        buf_full_next   = buf_full_reg;
        shreg_next      = shreg_reg;
        cnt_next        = cnt_reg;
        words_done_next = words_done_reg;

        // accept only happens with the buffer empty, so it never collides with a drain below
        if (accept) begin
            buf_data_next = in_data;
            buf_full_next = 1'b1;
        end

        case (state_reg)
            IDLE: begin
                if (buf_full_reg) begin
                    shreg_next    = buf_data_reg;
                    cnt_next      = CW'(WIDTH);
                    buf_full_next = 1'b0;
                    state_next    = SHIFT;
                end
            end
            SHIFT: begin
                if (consume) begin
                    if (!last_bit) begin
                        shreg_next = shreg_shifted;
                        cnt_next   = cnt_reg - CW'(1);
                    end else begin
                        words_done_next = words_done_reg + 8'd1;
                        if (buf_full_reg) begin
                            shreg_next    = buf_data_reg;
                            cnt_next      = CW'(WIDTH);
                            buf_full_next = 1'b0;
                        end else begin
                            shreg_next = '0;
                            cnt_next   = '0;
                            state_next = IDLE;
                        end
                    end
                end
            end
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg      <= IDLE;
            buf_data_reg   <= '0;
            buf_full_reg   <= 1'b0;
            shreg_reg      <= '0;
            cnt_reg        <= '0;
            words_done_reg <= '0;
        end else begin
            state_reg      <= state_next;
            buf_data_reg   <= buf_data_next;
            buf_full_reg   <= buf_full_next;
            shreg_reg      <= shreg_next;
            cnt_reg        <= cnt_next;
            words_done_reg <= words_done_next;
        end
    end

    assign in_ready   = !buf_full_reg;
    assign out_valid  = shifting;
    assign out_bit    = shifting && shreg_reg[0];
    assign out_last   = last_bit;
    assign busy       = shifting || buf_full_reg;
    assign words_done = words_done_reg;

endmodule

// File: doc/bit_serializer.md
BIT_SERIALIZER -- requirements
Module: bit_serializer

Interface
REQ-001 SHALL have parameter WIDTH, default 4, meaning the bits per input word (legal range 2..32).
REQ-002 SHALL have port clk, input, 1 bit, the single clock; all state updates on its rising edge.
REQ-003 SHALL have port rst, input, 1 bit; reset is synchronous and active-high.
REQ-004 SHALL have port in_valid, input, 1 bit, meaning an upstream word is offered.
REQ-005 SHALL have port in_ready, output, 1 bit, meaning the holding buffer can accept a word.
REQ-006 SHALL have port in_data, input, WIDTH bits, meaning the word to serialize.
REQ-007 SHALL have port out_valid, output, 1 bit, meaning out_bit is presented to the downstream bit-serial popcount stage.
REQ-008 SHALL have port out_ready, input, 1 bit, meaning downstream consumes out_bit this cycle.
REQ-009 SHALL have port out_bit, output, 1 bit, meaning the current bit, LSB first.
REQ-010 SHALL have port out_last, output, 1 bit, meaning the current bit closes its word.
REQ-011 SHALL have port busy, output, 1 bit, high when the state is SHIFT or the buffer is full.
REQ-012 SHALL have port words_done, output, 8 bits, counting words whose last bit was consumed; wraps 255->0.

Function
REQ-013 SHALL hold one-entry buffer (buf_data, buf_full), shift register shreg (WIDTH bits), remaining-bit counter cnt (width clog2(WIDTH+1)), and FSM state IDLE or SHIFT.
REQ-014 in_ready SHALL equal !buf_full, combinational from registered state only; accept = in_valid && in_ready.
REQ-015 On accept, the buffer SHALL capture in_data and set buf_full at that edge.
REQ-016 IDLE with buf_full: next edge SHALL load shreg <= buf_data, cnt <= WIDTH, clear buf_full, go to SHIFT.
REQ-017 In IDLE, out_valid, out_bit, out_last SHALL be 0.
REQ-018 In SHIFT, out_valid SHALL be 1, out_bit SHALL equal shreg[0], out_last SHALL be (cnt == 1) unless modified by REQ-027.
REQ-019 Consume = out_valid && out_ready; without consume, shreg, cnt and outputs SHALL hold (stall).
REQ-020 On consume with !out_last: shreg SHALL shift right by one (zero fill), cnt SHALL decrement.
REQ-021 On consume with out_last and buf_full: SHALL reload from buffer as in REQ-016 and stay in SHIFT (no bubble cycle); words_done increments.
REQ-022 On consume with out_last and !buf_full: SHALL go to IDLE; words_done increments.
REQ-023 Accept and buffer drain in the same cycle cannot coincide (in_ready low while buf_full); a word offered then SHALL wait.
REQ-024 Latency: word accepted at edge E SHALL produce out_valid high after edge E+1 when idle; exactly WIDTH consumes per word without REQ-027.

Reset
REQ-025 While rst high at an edge: state <= IDLE, buf_full <= 0, cnt <= 0, shreg <= 0, words_done <= 0; hence in_ready = 1, out_valid = 0, out_bit = 0, out_last = 0, busy = 0.
REQ-026 Reset mid-word SHALL discard the shifting word and buffered word without asserting out_last; rst has priority over accept and consume.

Configuration
REQ-027 Macro BIT_SERIALIZER_EARLY_EXIT_EN: when defined, out_last SHALL be (cnt == 1) || (shreg >> 1 == 0), ending a word once no set bits remain above the current one (word 0 emits one bit 0 with out_last); when undefined, out_last SHALL be (cnt == 1) only and every word emits WIDTH bits.

Verification
REQ-028 Reset, then in_data=4'b1010 with out_ready=1 -> out_bit sequence 0,1,0,1, out_last on 4th bit, words_done=1, then IDLE.
REQ-029 Words 4'b0111 then 4'b0001 offered back-to-back, out_ready=1 -> 8 consecutive out_valid cycles, bits 1,1,1,0,1,0,0,0, no bubble, in_ready low while buffer full.
REQ-030 out_ready low for 3 cycles mid-word 4'b1100 -> out_bit/out_last/cnt frozen, then resume with no lost or duplicated bits.
REQ-031 With BIT_SERIALIZER_EARLY_EXIT_EN, words 4'b0000 and 4'b0011 -> 1 bit (0, last) and 2 bits (1,1, last); without it, 4 bits each.
REQ-032 rst asserted after 2nd bit of 4'b1111 with buffer full -> next cycle out_valid=0, in_ready=1, words_done=0, no out_last seen.
REQ-033 256 words of 4'b0000 -> words_done wraps to 0.
